// File: rtl/signedness_pkg.sv
// Shared definitions for the signedness datapath: FSM encoding and saturation bounds.
package signedness_pkg;

    typedef enum logic {
        ST_ACC  = 1'b0,
        ST_DONE = 1'b1
    } state_e;

    // Bounds are returned as 32-bit patterns; callers truncate to their width.
    function automatic logic [31:0] smax_f(int unsigned w);
        return (32'd1 << (w - 1)) - 32'd1;
    endfunction

    function automatic logic [31:0] smin_f(int unsigned w);
        return 32'd1 << (w - 1);
    endfunction

    function automatic logic [31:0] umax_f(int unsigned w);
        return (w >= 32) ? 32'hFFFF_FFFF : (32'd1 << w) - 32'd1;
    endfunction

endpackage

// File: rtl/signedness_acc_sat_add.sv
// Combinational saturating adder: acc + extended x, computed one bit wider
// than the accumulator so overflow never wraps before it is detected.
module sat_add
    import signedness_pkg::*;
#(
    parameter int unsigned W_IN   = 5,
    parameter int unsigned W_ACC  = 8,
    parameter bit          SIGNED = 1'b1
) (
    input  logic [W_ACC-1:0] acc,
    input  logic [W_IN-1:0]  x,
    output logic [W_ACC-1:0] sum,
    output logic             clamp
);

    localparam int unsigned W_EXT = W_ACC + 1;

    logic [W_EXT-1:0] acc_e;
    logic [W_EXT-1:0] x_e;
    logic [W_EXT-1:0] raw;

    generate
        if (SIGNED) begin : g_signed
            localparam logic [W_ACC-1:0] MAX = W_ACC'(smax_f(W_ACC));
            localparam logic [W_ACC-1:0] MIN = W_ACC'(smin_f(W_ACC));

            // Overflow when the guard bit disagrees with the result sign bit.
            always_comb begin
                acc_e = {acc[W_ACC-1], acc};
                x_e   = {{(W_EXT - W_IN){x[W_IN-1]}}, x};
                raw   = acc_e + x_e;
                clamp = raw[W_ACC] ^ raw[W_ACC-1];
                sum   = raw[W_ACC-1:0];
                if (clamp) begin
                    sum = raw[W_ACC] ? MIN : MAX;
                end
            end
        end else begin : g_unsigned
            localparam logic [W_ACC-1:0] MAX = W_ACC'(umax_f(W_ACC));

            always_comb begin
                acc_e = {1'b0, acc};
                x_e   = {{(W_EXT - W_IN){1'b0}}, x};
                raw   = acc_e + x_e;
                clamp = raw[W_ACC];
                sum   = clamp ? MAX : raw[W_ACC-1:0];
            end
        end
    endgenerate

endmodule

// File: rtl/signedness_acc.sv
// Frame accumulator: sums FRAME_LEN (signed, unsigned) sample pairs with
// per-step saturation and presents the result on a valid/ready port.
module signedness_acc
    import signedness_pkg::*;
#(
    parameter int unsigned W_IN      = 5,
    parameter int unsigned W_ACC     = 8,
    parameter int unsigned FRAME_LEN = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [W_IN-1:0]  in_c,
    input  logic        [W_IN-1:0]  in_cu,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [W_ACC-1:0] sum_s,
    output logic        [W_ACC-1:0] sum_u,
    output logic                    sat_s,
    output logic                    sat_u
);

    localparam int unsigned CNT_W = $clog2(FRAME_LEN);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_LEN - 1);

    state_e             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [W_ACC-1:0]   sum_s_q, sum_s_d;
    logic [W_ACC-1:0]   sum_u_q, sum_u_d;
    logic               sat_s_q, sat_u_q;
    logic               clamp_s, clamp_u;
    logic               in_ready_q, out_valid_q;

    sat_add #(.W_IN(W_IN), .W_ACC(W_ACC), .SIGNED(1'b1)) u_sat_s (
        .acc   (sum_s_q),
        .x     (in_c),
        .sum   (sum_s_d),
        .clamp (clamp_s)
    );

    sat_add #(.W_IN(W_IN), .W_ACC(W_ACC), .SIGNED(1'b0)) u_sat_u (
        .acc   (sum_u_q),
        .x     (in_cu),
        .sum   (sum_u_d),
        .clamp (clamp_u)
    );

    // in_ready is 1 only in ACC, so an accept there is simply in_valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_ACC;
            cnt_q       <= '0;
            sum_s_q     <= '0;
            sum_u_q     <= '0;
            sat_s_q     <= 1'b0;
            sat_u_q     <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                ST_ACC: begin
                    if (in_valid) begin
                        sum_s_q <= sum_s_d;
                        sum_u_q <= sum_u_d;
                        sat_s_q <= sat_s_q | clamp_s;
                        sat_u_q <= sat_u_q | clamp_u;
                        if (cnt_q == CNT_LAST) begin
                            cnt_q       <= '0;
                            state_q     <= ST_DONE;
                            in_ready_q  <= 1'b0;
                            out_valid_q <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state_q     <= ST_ACC;
                        sum_s_q     <= '0;
                        sum_u_q     <= '0;
                        sat_s_q     <= 1'b0;
                        sat_u_q     <= 1'b0;
                        in_ready_q  <= 1'b1;
                        out_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ST_ACC;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign sum_s     = sum_s_q;
    assign sum_u     = sum_u_q;
    assign sat_s     = sat_s_q;
    assign sat_u     = sat_u_q;

endmodule

// File: tb/tb_signedness_acc.sv
// Self-checking bench for signedness_acc: an integer reference model pushes
// expected frame results to a scoreboard that is popped when out_valid rises.
module tb_signedness_acc;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic signed [4:0] in_c = '0;
    logic [4:0]        in_cu = '0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic signed [7:0] sum_s;
    logic [7:0]        sum_u;
    logic              sat_s;
    logic              sat_u;

    typedef struct {
        int s;
        int u;
        bit ss;
        bit su;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    int m_s, m_u, m_n;
    bit m_ss, m_su;

    signedness_acc dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_c      (in_c),
        .in_cu     (in_cu),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum_s     (sum_s),
        .sum_u     (sum_u),
        .sat_s     (sat_s),
        .sat_u     (sat_u)
    );

    always #5 clk = ~clk;

    task automatic model_clear();
        m_s = 0; m_u = 0; m_n = 0; m_ss = 1'b0; m_su = 1'b0;
    endtask

    // Reference: plain integer sums clamped after every sample.
    task automatic model_add(int c, int cu);
        exp_t e;
        m_s = m_s + c;
        if (m_s > 127)  begin m_s = 127;  m_ss = 1'b1; end
        if (m_s < -128) begin m_s = -128; m_ss = 1'b1; end
        m_u = m_u + cu;
        if (m_u > 255)  begin m_u = 255;  m_su = 1'b1; end
        m_n++;
        if (m_n == 16) begin
            e.s = m_s; e.u = m_u; e.ss = m_ss; e.su = m_su;
            sb.push_back(e);
            model_clear();
        end
    endtask

    // One accepted sample: presented at negedge, taken at the next posedge.
    task automatic drive(int c, int cu);
        @(negedge clk);
        in_valid = 1'b1;
        in_c     = 5'(c);
        in_cu    = 5'(cu);
        @(posedge clk);
        model_add(c, cu);
    endtask

    task automatic wait_out(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            in_valid = 1'b0;
            if (out_valid) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic release_out();
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic pop_exp(output exp_t e);
        if (sb.size() == 0) begin
            e.s = 9999; e.u = 9999; e.ss = 1'b0; e.su = 1'b0;
        end else begin
            e = sb.pop_front();
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst       = 1'b1;
        in_valid  = 1'($urandom);
        in_c      = 5'($urandom);
        in_cu     = 5'($urandom);
        out_ready = 1'($urandom);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            in_valid = 1'($urandom);
            in_c     = 5'($urandom);
            in_cu    = 5'($urandom);
            checks++;
            if ({in_ready, out_valid, sum_s, sum_u, sat_s, sat_u} !== {1'b1, 1'b0, 8'd0, 8'd0, 1'b0, 1'b0}) begin
                errors++;
                $display("FAIL reset_state edge%0d: rdy=%b vld=%b s=%0d u=%0d ss=%b su=%b, required rdy=1 vld=0 rest 0",
                         k, in_ready, out_valid, sum_s, sum_u, sat_s, sat_u);
            end
        end
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        model_clear();
    endtask

    task automatic test_contrast();
        exp_t e;
        bit ok;
        for (int i = 0; i < 15; i++) drive(-4, 28);
        @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL contrast_early_valid: out_valid=%b required 0", out_valid);
        end
        drive(-4, 28);
        @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL contrast_valid_latency: out_valid=%b required 1", out_valid);
        end
        wait_out(ok);
        pop_exp(e);
        checks++;
        if (!ok || sum_s !== 8'(e.s) || sum_u !== 8'(e.u) || {sat_s, sat_u} !== {e.ss, e.su}) begin
            errors++;
            $display("FAIL contrast_sums: s=%0d u=%0d ss=%b su=%b, required s=%0d u=%0d ss=%b su=%b",
                     sum_s, sum_u, sat_s, sat_u, e.s, e.u, e.ss, e.su);
        end
        release_out();
    endtask

    task automatic test_per_step_clamp();
        exp_t e;
        bit ok;
        for (int i = 0; i < 9; i++) drive(15, 0);
        for (int i = 0; i < 7; i++) drive(-16, 0);
        wait_out(ok);
        pop_exp(e);
        checks++;
        if (!ok || sum_s !== 8'(e.s) || sat_s !== e.ss || sum_u !== 8'(e.u) || sat_u !== e.su) begin
            errors++;
            $display("FAIL clamp_pos: s=%0d ss=%b u=%0d su=%b, required s=%0d ss=%b u=%0d su=%b",
                     sum_s, sat_s, sum_u, sat_u, e.s, e.ss, e.u, e.su);
        end
        release_out();
        for (int i = 0; i < 16; i++) drive(-16, 0);
        wait_out(ok);
        pop_exp(e);
        checks++;
        if (!ok || sum_s !== 8'(e.s) || sat_s !== e.ss || sat_u !== e.su) begin
            errors++;
            $display("FAIL clamp_neg: s=%0d ss=%b su=%b, required s=%0d ss=%b su=%b",
                     sum_s, sat_s, sat_u, e.s, e.ss, e.su);
        end
        release_out();
    endtask

    task automatic test_backpressure();
        exp_t e;
        bit ok;
        for (int i = 0; i < 16; i++) drive($urandom_range(0, 31) - 16, $urandom_range(0, 31));
        pop_exp(e);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_c     = 5'($urandom);
            in_cu    = 5'($urandom);
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || sum_s !== 8'(e.s) || sum_u !== 8'(e.u)
                || sat_s !== e.ss || sat_u !== e.su) begin
                errors++;
                $display("FAIL backpressure_hold cyc%0d: vld=%b rdy=%b s=%0d u=%0d ss=%b su=%b, required vld=1 rdy=0 s=%0d u=%0d ss=%b su=%b",
                         k, out_valid, in_ready, sum_s, sum_u, sat_s, sat_u, e.s, e.u, e.ss, e.su);
            end
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b0;
        checks++;
        if ({in_ready, out_valid, sum_s, sum_u, sat_s, sat_u} !== {1'b1, 1'b0, 8'd0, 8'd0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL backpressure_release: rdy=%b vld=%b s=%0d u=%0d ss=%b su=%b, required rdy=1 vld=0 rest 0",
                     in_ready, out_valid, sum_s, sum_u, sat_s, sat_u);
        end
        wait_out(ok);
        checks++;
        if (ok) begin
            errors++;
            $display("FAIL backpressure_no_accept: out_valid=1 required 0 (samples taken while stalled)");
        end
    endtask

    task automatic test_reset_mid_frame();
        exp_t e;
        bit ok;
        for (int i = 0; i < 7; i++) drive(0, 31);
        @(negedge clk);
        rst = 1'b1;
        in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_clear();
        for (int i = 0; i < 16; i++) drive(0, 1);
        wait_out(ok);
        pop_exp(e);
        checks++;
        if (!ok || sum_u !== 8'(e.u) || sat_u !== e.su || sum_s !== 8'(e.s)) begin
            errors++;
            $display("FAIL reset_mid_frame: u=%0d su=%b s=%0d, required u=%0d su=%b s=%0d",
                     sum_u, sat_u, sum_s, e.u, e.su, e.s);
        end
        release_out();
    endtask

    task automatic test_bubbly();
        exp_t e;
        for (int i = 0; i < 31; i++) begin
            if (i % 2 == 0) begin
                drive(1, 2);
            end else begin
                @(negedge clk);
                in_valid = 1'b0;
                checks++;
                if (out_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL bubbly_early_valid cyc%0d: out_valid=%b required 0", i, out_valid);
                end
                @(posedge clk);
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
        pop_exp(e);
        checks++;
        if (out_valid !== 1'b1 || sum_s !== 8'(e.s) || sum_u !== 8'(e.u) || sat_s !== e.ss || sat_u !== e.su) begin
            errors++;
            $display("FAIL bubbly_result: vld=%b s=%0d u=%0d ss=%b su=%b, required vld=1 s=%0d u=%0d ss=%b su=%b",
                     out_valid, sum_s, sum_u, sat_s, sat_u, e.s, e.u, e.ss, e.su);
        end
        release_out();
    endtask

    initial begin
        model_clear();
        test_reset();
        test_contrast();
        test_per_step_clamp();
        test_backpressure();
        test_reset_mid_frame();
        test_bubbly();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/signedness_acc.md
# signedness_acc

Frame accumulator that sits directly downstream of the `signedness` block and consumes its 5-bit results. It consumes the signed result `c` and the unsigned result `cu` as one sample pair per handshake. It sums `FRAME_LEN` pairs into a signed sum and an unsigned sum, each with saturating arithmetic. It then presents both sums, plus sticky saturation flags, on a valid/ready output port.

## Interface
Parameters:
- `W_IN`, 5, width of `in_c` / `in_cu`; matches `signedness` outputs.
- `W_ACC`, 8, width of both accumulators.
- `FRAME_LEN`, 16, samples per frame; must be ≥ 2.

Ports:
- `clk`  in  1  clock; all logic is on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  sample pair present.
- `in_ready`  out  1  block accepts a sample this cycle.
- `in_c`  in  signed [W_IN-1:0]  signed sample; sign-extended to `W_ACC`.
- `in_cu`  in  unsigned [W_IN-1:0]  unsigned sample; zero-extended to `W_ACC`.
- `out_valid`  out  1  frame result available.
- `out_ready`  in  1  consumer takes the result.
- `sum_s`  out  signed [W_ACC-1:0]  saturated signed frame sum.
- `sum_u`  out  unsigned [W_ACC-1:0]  saturated unsigned frame sum.
- `sat_s`  out  1  sticky: signed clamp occurred this frame.
- `sat_u`  out  1  sticky: unsigned clamp occurred this frame.

## Operation
- States: ACC and DONE.
- Reset state: ACC, `cnt`=0, `sum_s`=0, `sum_u`=0, `sat_s`=0, `sat_u`=0, `out_valid`=0, `in_ready`=1.
- ACC:
  - `in_ready`=1, `out_valid`=0.
  - An accept is `in_valid & in_ready`. Each accept updates both sums and increments `cnt`.
  - The accept with `cnt`==`FRAME_LEN`-1 moves the block to DONE; `cnt` returns to 0.
- DONE:
  - `in_ready`=0, `out_valid`=1; `in_valid` is ignored.
  - Sums and flags hold stable.
  - On `out_ready`=1, the next cycle is ACC with sums and flags cleared to 0.
- Signed update: `sum_s` ← clamp(`sum_s` + sext(`in_c`)) to [-2^(W_ACC-1), 2^(W_ACC-1)-1]. On a clamp, set `sat_s`.
- Unsigned update: `sum_u` ← min(`sum_u` + zext(`in_cu`), 2^W_ACC-1). On a clamp, set `sat_u`.
- Clamping is applied at every step, and accumulation continues from the clamped value. The sum is not the true total clamped once at the end.
- Internal sums are computed at `W_ACC`+1 bits; overflow is detected from that extra bit. No intermediate wrap-around is allowed.
- The same bit pattern may be presented on both inputs, e.g. 5'b11100. It is treated as -4 on the signed path and 28 on the unsigned path.

## Timing
- Accept latency: a sample accepted at edge k is reflected in the sums at edge k+1.
- `out_valid` rises one cycle after the final accept of the frame.
- The out handshake completes in the cycle where `out_valid & out_ready`. `in_ready` returns to 1 in the following cycle; there is no input/output overlap.
- Minimum period is `FRAME_LEN`+1 cycles per frame.
- Gaps in `in_valid` stall `cnt`. There is no timeout.
- `rst` overrides everything. Reset mid-frame discards partial sums, and reset in DONE drops the pending result. Both go to the reset state on the next edge.
- All outputs are registered; there is no combinational path from `in_*` or `out_ready` to any output.

## Structure
- Shared package `signedness_pkg` holds:
  - state encoding `ST_ACC`=0, `ST_DONE`=1;
  - functions/constants for the signed max/min and unsigned max as functions of `W_ACC`.
- Sub-module `sat_add`:
  - parameters `W_IN`, `W_ACC`, `SIGNED`; one instance per path;
  - inputs `acc` and `x`; outputs the clamped sum and `clamp`;
  - purely combinational.
- Top level holds the FSM, `cnt` ($clog2(`FRAME_LEN`) bits), the registers and the flags.

## Test plan
All scenarios use default parameters.
- **Reset:** hold `rst` 2 cycles with random inputs. All outputs read 0, `in_ready`=1 and `out_valid`=0 from the first post-reset edge.
- **Signedness contrast:** 16 accepts of `in_c`=5'b11100, `in_cu`=5'b11100.
  - Required: `sum_s`=-64, `sat_s`=0, `sum_u`=255, `sat_u`=1.
  - `out_valid` rises exactly 1 cycle after the 16th accept.
- **Per-step clamp:** 9 accepts of `in_c`=15, then 7 accepts of `in_c`=-16.
  - Required: `sum_s`=15 (127-112), `sat_s`=1.
  - Also 16 accepts of `in_c`=-16 → `sum_s`=-128, `sat_s`=1.
- **Backpressure:** complete a frame and hold `out_ready`=0 for 5 cycles while driving `in_valid`=1.
  - Required: outputs stable, `in_ready`=0, no accepts.
  - Then pulse `out_ready` for 1 cycle. Next cycle: `in_ready`=1, sums and flags 0.
- **Reset mid-frame:** accept 7 samples of `in_cu`=31, assert `rst` for 1 cycle, then run 16 samples of `in_cu`=1. Required: `sum_u`=16, `sat_u`=0.
- **Bubbly input:** `in_valid` toggles 1/0 every cycle with `in_c`=1, `in_cu`=2. Required: `out_valid` after the 16th accept (cycle 32), `sum_s`=16, `sum_u`=32.
